// File: rtl/io_periph_hub.sv
// Memory-mapped IO hub: decodes a 256-byte IO window out of the CPU data bus,
// drives LEDs, samples switches and debounced buttons, and raises a level IRQ.
module io_periph_hub #(
    parameter int          LED_W      = 8,
    parameter int          SW_W       = 4,
    parameter int          BTN_N      = 1,
    parameter int          DEB_CYCLES = 16,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic             memwrite,
    input  logic [31:0]      ram_rdata,
    output logic             ram_we,
    output logic [31:0]      rdata,
    input  logic [SW_W-1:0]  slide,
    input  logic [BTN_N-1:0] btn,
    output logic [LED_W-1:0] led,
    output logic             irq
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    localparam logic [7:0] OFF_LED     = 8'h00;
    localparam logic [7:0] OFF_SW      = 8'h04;
    localparam logic [7:0] OFF_BTN_LVL = 8'h08;
    localparam logic [7:0] OFF_BTN_EVT = 8'h0C;
    localparam logic [7:0] OFF_IRQ_EN  = 8'h10;
    localparam logic [7:0] OFF_LED_TGL = 8'h14;

    logic             io_sel;
    logic             wr_en;
    logic [31:0]      io_rdata;

    logic [LED_W-1:0] led_reg, led_next;
    logic [BTN_N-1:0] irq_en_reg, irq_en_next;
    logic [BTN_N-1:0] evt_reg, evt_next, evt_clr;
    logic [SW_W-1:0]  sw_sync1_reg, sw_sync2_reg;
    logic [BTN_N-1:0] btn_sync1_reg, btn_sync2_reg;
    logic [BTN_N-1:0] stable_lvl;
    logic [BTN_N-1:0] stable_d_reg;

    logic unused_wdata;
    assign unused_wdata = ^wdata;

    assign io_sel = (addr[31:8] == IO_BASE[31:8]);
    assign wr_en  = io_sel & memwrite;
    assign ram_we = memwrite & ~io_sel;

    // Full 8-bit offset match, so misaligned and unmapped offsets fall to default.
    always_comb begin
        io_rdata = '0;
        case (addr[7:0])
            OFF_LED:     io_rdata[LED_W-1:0] = led_reg;
            OFF_SW:      io_rdata[SW_W-1:0]  = sw_sync2_reg;
            OFF_BTN_LVL: io_rdata[BTN_N-1:0] = stable_lvl;
            OFF_BTN_EVT: io_rdata[BTN_N-1:0] = evt_reg;
            OFF_IRQ_EN:  io_rdata[BTN_N-1:0] = irq_en_reg;
            default:     io_rdata = '0;
        endcase
    end

    assign rdata = io_sel ? io_rdata : ram_rdata;

    always_comb begin
        led_next    = led_reg;
        irq_en_next = irq_en_reg;
        evt_clr     = '0;
        if (wr_en) begin
            case (addr[7:0])
                OFF_LED:     led_next    = wdata[LED_W-1:0];
                OFF_LED_TGL: led_next    = led_reg ^ wdata[LED_W-1:0];
                OFF_BTN_EVT: evt_clr     = wdata[BTN_N-1:0];
                OFF_IRQ_EN:  irq_en_next = wdata[BTN_N-1:0];
                default:     ;
            endcase
        end
        // A new press in the same cycle as a clear must not be lost.
        evt_next = (evt_reg & ~evt_clr) | (stable_lvl & ~stable_d_reg);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_reg       <= '0;
            irq_en_reg    <= '0;
            evt_reg       <= '0;
            sw_sync1_reg  <= '0;
            sw_sync2_reg  <= '0;
            btn_sync1_reg <= '0;
            btn_sync2_reg <= '0;
            stable_d_reg  <= '0;
        end else begin
            led_reg       <= led_next;
            irq_en_reg    <= irq_en_next;
            evt_reg       <= evt_next;
            sw_sync1_reg  <= slide;
            sw_sync2_reg  <= sw_sync1_reg;
            btn_sync1_reg <= btn;
            btn_sync2_reg <= btn_sync1_reg;
            stable_d_reg  <= stable_lvl;
        end
    end

    // Per-button debouncer: the synchronized level must differ from the
    // stable level for DEB_CYCLES consecutive edges before it is accepted.
    generate
        for (genvar gi = 0; gi < BTN_N; gi++) begin : g_deb
            logic [CNT_W-1:0] cnt_reg;
            logic             stable_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_reg    <= '0;
                    stable_reg <= 1'b0;
                end else if (btn_sync2_reg[gi] == stable_reg) begin
                    cnt_reg    <= '0;
                end else if (cnt_reg == DEB_LAST) begin
                    stable_reg <= btn_sync2_reg[gi];
                    cnt_reg    <= '0;
                end else begin
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                end
            end

            assign stable_lvl[gi] = stable_reg;
        end
    endgenerate

    assign led = led_reg;
    assign irq = |(evt_reg & irq_en_reg);

endmodule

// File: tb/tb_io_periph_hub.sv
// Directed bench for io_periph_hub: bus decode, LED/toggle, switch sync,
// button debounce/event/IRQ behaviour and asynchronous reset.
module tb_io_periph_hub;

    localparam logic [31:0] A_LED  = 32'hFFFF_FF00;
    localparam logic [31:0] A_SW   = 32'hFFFF_FF04;
    localparam logic [31:0] A_LVL  = 32'hFFFF_FF08;
    localparam logic [31:0] A_EVT  = 32'hFFFF_FF0C;
    localparam logic [31:0] A_IEN  = 32'hFFFF_FF10;
    localparam logic [31:0] A_TGL  = 32'hFFFF_FF14;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        memwrite;
    logic [31:0] ram_rdata;
    logic        ram_we;
    logic [31:0] rdata;
    logic [3:0]  slide;
    logic [0:0]  btn;
    logic [7:0]  led;
    logic        irq;

    int errors = 0;
    int checks = 0;

    io_periph_hub #(
        .LED_W(8), .SW_W(4), .BTN_N(1), .DEB_CYCLES(16), .IO_BASE(32'hFFFF_FF00)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .memwrite(memwrite),
        .ram_rdata(ram_rdata), .ram_we(ram_we), .rdata(rdata), .slide(slide),
        .btn(btn), .led(led), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; memwrite = 1'b1;
        tick();
        memwrite = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led actual=%h required=00", led); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq actual=%b required=0", irq); end
        addr = A_LED; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_led_rd actual=%h required=0", rdata); end
        addr = 32'h0000_0040; memwrite = 1'b1; ram_rdata = 32'hDEAD_BEEF; #1;
        checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL reset_ram_we actual=%b required=1", ram_we); end
        checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL reset_ram_rd actual=%h required=deadbeef", rdata); end
        memwrite = 1'b0;
        tick(); tick();
        reset = 1'b1;
        $display("reset released");
    endtask

    task automatic test_led();
        addr = A_LED; wdata = 32'h0000_00A5; memwrite = 1'b1; #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL led_wr_ram_we actual=%b required=0", ram_we); end
        tick(); memwrite = 1'b0; #1;
        checks++; if (led !== 8'hA5) begin errors++; $display("FAIL led_write actual=%h required=a5", led); end
        addr = A_TGL; wdata = 32'h0000_000F; memwrite = 1'b1; #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL tgl_wr_ram_we actual=%b required=0", ram_we); end
        tick(); memwrite = 1'b0; #1;
        checks++; if (led !== 8'hAA) begin errors++; $display("FAIL led_toggle actual=%h required=aa", led); end
        addr = A_LED; #1;
        checks++; if (rdata !== 32'h0000_00AA) begin errors++; $display("FAIL led_read actual=%h required=000000aa", rdata); end
        addr = A_TGL; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL tgl_read actual=%h required=0", rdata); end
        $display("led: write a5, toggle 0f -> %h", led);
    endtask

    task automatic test_ram();
        addr = 32'h0000_0040; wdata = 32'h0000_0033; memwrite = 1'b1; ram_rdata = 32'h1234_5678; #1;
        checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL ram_we actual=%b required=1", ram_we); end
        checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("FAIL ram_read actual=%h required=12345678", rdata); end
        tick(); memwrite = 1'b0; #1;
        checks++; if (led !== 8'hAA) begin errors++; $display("FAIL ram_led_keep actual=%h required=aa", led); end
        addr = 32'hFFFF_FE00; #1;
        checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("FAIL near_window_read actual=%h required=12345678", rdata); end
        $display("ram: store 0x40 ram_we path checked");
    endtask

    task automatic test_unmapped();
        addr = 32'hFFFF_FF18; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL unmapped_read actual=%h required=0", rdata); end
        addr = 32'hFFFF_FF01; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL misaligned_read actual=%h required=0", rdata); end
        cpu_write(32'hFFFF_FF01, 32'h0000_0055);
        checks++; if (led !== 8'hAA) begin errors++; $display("FAIL misaligned_write actual=%h required=aa", led); end
        cpu_write(A_SW, 32'h0000_000F);
        addr = A_SW; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL ro_write_sw actual=%h required=0", rdata); end
        $display("unmapped/misaligned accesses checked");
    endtask

    task automatic test_switch();
        addr = A_SW; slide = 4'b1001; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL sw_cycle0 actual=%h required=0", rdata); end
        tick();
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL sw_cycle1 actual=%h required=0", rdata); end
        tick();
        checks++; if (rdata !== 32'h9) begin errors++; $display("FAIL sw_cycle2 actual=%h required=9", rdata); end
        $display("switch: 1001 visible after 2 cycles");
    endtask

    task automatic test_glitch();
        btn = 1'b1;
        repeat (5) tick();
        btn = 1'b0;
        repeat (25) tick();
        addr = A_LVL; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL glitch_lvl actual=%h required=0", rdata); end
        addr = A_EVT; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL glitch_evt actual=%h required=0", rdata); end
        $display("glitch: 5-cycle pulse rejected");
    endtask

    task automatic test_button();
        btn = 1'b1; addr = A_LVL;
        repeat (17) tick();
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL btn_lvl_17 actual=%h required=0", rdata); end
        tick();
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL btn_lvl_18 actual=%h required=1", rdata); end
        addr = A_EVT; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL btn_evt_18 actual=%h required=0", rdata); end
        tick();
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL btn_evt_19 actual=%h required=1", rdata); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked actual=%b required=0", irq); end
        $display("button: level at 18, event at 19");
    endtask

    task automatic test_irq();
        cpu_write(A_IEN, 32'h1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set actual=%b required=1", irq); end
        cpu_write(A_EVT, 32'h0);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL evt_write0 actual=%b required=1", irq); end
        cpu_write(A_EVT, 32'h1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear actual=%b required=0", irq); end
        btn = 1'b0;
        repeat (20) tick();
        addr = A_LVL; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL release_lvl actual=%h required=0", rdata); end
        addr = A_EVT; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL release_evt actual=%h required=0", rdata); end
        btn = 1'b1;
        repeat (18) tick();
        cpu_write(A_EVT, 32'h1);
        addr = A_EVT; #1;
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL set_wins_evt actual=%h required=1", rdata); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL set_wins_irq actual=%b required=1", irq); end
        $display("irq: clear and same-cycle set checked");
    endtask

    task automatic test_async_reset();
        cpu_write(A_LED, 32'h0000_00FF);
        checks++; if (led !== 8'hFF) begin errors++; $display("FAIL pre_reset_led actual=%h required=ff", led); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL async_led actual=%h required=00", led); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL async_irq actual=%b required=0", irq); end
        tick(); tick();
        reset = 1'b1;
        addr = A_LVL;
        repeat (17) tick();
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL post_reset_lvl_17 actual=%h required=0", rdata); end
        tick();
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL post_reset_lvl_18 actual=%h required=1", rdata); end
        $display("async reset: outputs cleared, debounce restarted");
    endtask

    initial begin
        reset = 1'b0; addr = '0; wdata = '0; memwrite = 1'b0;
        ram_rdata = '0; slide = '0; btn = '0;
        test_reset();
        test_led();
        test_ram();
        test_unmapped();
        test_switch();
        test_glitch();
        test_button();
        test_irq();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
